// File: rtl/sti_dac_pkg.sv
// rtl/sti_dac_pkg.sv - shared types and helpers for the STI/DAC serial transmitter
package sti_dac_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FMT,
        ST_SHIFT,
        ST_PAD,
        ST_FIN,
        ST_DONE
    } state_t;

    function automatic int len_bits(input int code);
        return BYTE_W * (code + 1);
    endfunction

endpackage

// File: rtl/sti_oem_map.sv
// rtl/sti_oem_map.sv - byte counter and registered checkerboard bank/address mapper
module sti_oem_map
    import sti_dac_pkg::*;
#(
    parameter int BANKS  = 4,
    parameter int DEPTH  = 32,
    parameter int ROW_W  = 3,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [BYTE_W-1:0] data_o,
    output logic [BANKS-1:0]  odd_wr_o,
    output logic [BANKS-1:0]  even_wr_o,
    output logic              full_o,
    output logic              overflow_o
);

    localparam int TOTAL = 2 * BANKS * DEPTH;
    localparam int CNT_W = $clog2(TOTAL + 1);

    logic [CNT_W-1:0]  b_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BYTE_W-1:0] data_q;
    logic [BANKS-1:0]  odd_q;
    logic [BANKS-1:0]  even_q;
    logic              ovf_q;
    logic [BANKS-1:0]  pair_hot_d;

    assign full_o     = (b_q == CNT_W'(TOTAL));
    assign pair_hot_d = BANKS'(1) << (b_q >> (ADDR_W + 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q    <= '0;
            addr_q <= '0;
            data_q <= '0;
            odd_q  <= '0;
            even_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            odd_q  <= '0;
            even_q <= '0;
            data_q <= '0;
            if (wr_req_i) begin
                if (full_o) begin
                    ovf_q <= 1'b1;
                end else begin
                    addr_q <= b_q[ADDR_W:1];
                    data_q <= byte_i;
                    // Row parity flips the odd/even sense every 2^ROW_W bytes.
                    if (b_q[0] == b_q[ROW_W]) odd_q  <= pair_hot_d;
                    else                      even_q <= pair_hot_d;
                    b_q <= b_q + 1'b1;
                end
            end
        end
    end

    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign odd_wr_o   = odd_q;
    assign even_wr_o  = even_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/sti_dac_gen.sv
// rtl/sti_dac_gen.sv - word formatter, serial shifter and control FSM feeding the bank mapper
module sti_dac_gen
    import sti_dac_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 2,
    parameter int BANKS  = 4,
    parameter int DEPTH  = 32,
    parameter int ROW_W  = 3,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    output logic              pi_ready,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [LEN_W-1:0]  pi_length,
    input  logic              pi_fill,
    input  logic              pi_low,
    input  logic              pi_msb,
    input  logic              pi_end,
    output logic              so_data,
    output logic              so_valid,
    output logic [ADDR_W-1:0] oem_addr,
    output logic [7:0]        oem_dataout,
    output logic [BANKS-1:0]  odd_wr,
    output logic [BANKS-1:0]  even_wr,
    output logic              oem_finish,
    output logic              oem_overflow
);

    localparam int MAXL  = BYTE_W << LEN_W;
    localparam int CNT_W = $clog2(MAXL);
    localparam int WW    = (DATA_W > MAXL) ? DATA_W : MAXL;

    state_t            state_q;
    logic              pi_ready_q;
    logic              so_valid_q;
    logic              finish_q;
    logic              end_q, fill_q, low_q, msb_q;
    logic [DATA_W-1:0] data_q;
    logic [LEN_W-1:0]  len_q;
    logic [MAXL-1:0]   sr_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [BYTE_W-1:0] acc_q;

    int                len_l;
    logic [WW-1:0]     data_ext;
    logic [WW-1:0]     sel_d;
    logic [MAXL-1:0]   w_d;
    logic [MAXL-1:0]   rev_d;
    logic [MAXL-1:0]   word_d;
    logic              last_bit;
    logic              wr_req;
    logic [BYTE_W-1:0] wr_byte;
    logic              full;

    always_comb begin
        len_l    = len_bits(int'(len_q));
        data_ext = WW'(data_q);
        sel_d    = data_ext;
        if (len_l < DATA_W) begin
            if (low_q) sel_d = data_ext >> (DATA_W - len_l);
            else       sel_d = data_ext & ~({WW{1'b1}} << len_l);
        end else if (len_l > DATA_W) begin
            if (fill_q) sel_d = data_ext << (len_l - DATA_W);
        end
        w_d   = MAXL'(sel_d);
        rev_d = '0;
        for (int i = 0; i < MAXL; i++) rev_d[i] = w_d[MAXL-1-i];
        // Shift register is MSB-aligned so the first-sent bit always sits at the top.
        word_d = msb_q ? (w_d << (MAXL - len_l)) : rev_d;
    end

    assign last_bit = (int'(bit_cnt_q) == len_l - 1);
    assign wr_req   = ((state_q == ST_SHIFT) && (bit_cnt_q[2:0] == 3'b111)) ||
                      ((state_q == ST_PAD) && !full);
    assign wr_byte  = (state_q == ST_SHIFT) ? {acc_q[BYTE_W-2:0], sr_q[MAXL-1]} : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pi_ready_q <= 1'b0;
            so_valid_q <= 1'b0;
            finish_q   <= 1'b0;
            end_q      <= 1'b0;
            fill_q     <= 1'b0;
            low_q      <= 1'b0;
            msb_q      <= 1'b0;
            data_q     <= '0;
            len_q      <= '0;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            acc_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pi_ready_q && load) begin
                        data_q     <= pi_data;
                        len_q      <= pi_length;
                        fill_q     <= pi_fill;
                        low_q      <= pi_low;
                        msb_q      <= pi_msb;
                        end_q      <= pi_end;
                        pi_ready_q <= 1'b0;
                        state_q    <= ST_FMT;
                    end else if (pi_ready_q && pi_end) begin
                        pi_ready_q <= 1'b0;
                        state_q    <= ST_PAD;
                    end else begin
                        pi_ready_q <= 1'b1;
                    end
                end
                ST_FMT: begin
                    sr_q       <= word_d;
                    bit_cnt_q  <= '0;
                    so_valid_q <= 1'b1;
                    state_q    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sr_q      <= sr_q << 1;
                    acc_q     <= {acc_q[BYTE_W-2:0], sr_q[MAXL-1]};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        so_valid_q <= 1'b0;
                        if (end_q) begin
                            state_q <= ST_PAD;
                        end else begin
                            pi_ready_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                ST_PAD: begin
                    if (full) begin
                        finish_q <= 1'b1;
                        state_q  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    finish_q <= 1'b0;
                    state_q  <= ST_DONE;
                end
                ST_DONE: state_q <= ST_DONE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sti_oem_map #(
        .BANKS (BANKS),
        .DEPTH (DEPTH),
        .ROW_W (ROW_W)
    ) u_map (
        .clk        (clk),
        .rst_n      (reset_n),
        .wr_req_i   (wr_req),
        .byte_i     (wr_byte),
        .addr_o     (oem_addr),
        .data_o     (oem_dataout),
        .odd_wr_o   (odd_wr),
        .even_wr_o  (even_wr),
        .full_o     (full),
        .overflow_o (oem_overflow)
    );

    assign pi_ready   = pi_ready_q;
    assign so_valid   = so_valid_q;
    assign so_data    = so_valid_q & sr_q[MAXL-1];
    assign oem_finish = finish_q;

endmodule

// File: tb/tb_sti_dac_gen.sv
// tb/tb_sti_dac_gen.sv - scoreboard bench for sti_dac_gen against a bit-list reference model
module tb_sti_dac_gen;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 2;
    localparam int BANKS  = 4;
    localparam int DEPTH  = 32;
    localparam int ROW    = 8;
    localparam int ADDR_W = 5;
    localparam int TOTAL  = 2 * BANKS * DEPTH;

    typedef struct {
        logic [BANKS-1:0]  odd;
        logic [BANKS-1:0]  even;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        dat;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              load = 1'b0;
    logic              pi_ready;
    logic [DATA_W-1:0] pi_data = '0;
    logic [LEN_W-1:0]  pi_length = '0;
    logic              pi_fill = 1'b0;
    logic              pi_low = 1'b0;
    logic              pi_msb = 1'b0;
    logic              pi_end = 1'b0;
    logic              so_data;
    logic              so_valid;
    logic [ADDR_W-1:0] oem_addr;
    logic [7:0]        oem_dataout;
    logic [BANKS-1:0]  odd_wr;
    logic [BANKS-1:0]  even_wr;
    logic              oem_finish;
    logic              oem_overflow;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  mb      = 0;
    bit  exp_ovf = 1'b0;
    int  cyc     = 0;
    int  last_wr_cyc = -10;
    int  n_fin   = 0;
    bit  sq[$];
    wr_t wq[$];

    sti_dac_gen dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .pi_ready     (pi_ready),
        .pi_data      (pi_data),
        .pi_length    (pi_length),
        .pi_fill      (pi_fill),
        .pi_low       (pi_low),
        .pi_msb       (pi_msb),
        .pi_end       (pi_end),
        .so_data      (so_data),
        .so_valid     (so_valid),
        .oem_addr     (oem_addr),
        .oem_dataout  (oem_dataout),
        .odd_wr       (odd_wr),
        .even_wr      (even_wr),
        .oem_finish   (oem_finish),
        .oem_overflow (oem_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_byte(input logic [7:0] by);
        wr_t e;
        if (mb >= TOTAL) begin
            exp_ovf = 1'b1;
        end else begin
            e.addr = ADDR_W'((mb % (2 * DEPTH)) / 2);
            e.dat  = by;
            e.odd  = '0;
            e.even = '0;
            if ((mb % 2) == ((mb / ROW) % 2)) e.odd  = BANKS'(1) << (mb / (2 * DEPTH));
            else                              e.even = BANKS'(1) << (mb / (2 * DEPTH));
            wq.push_back(e);
            mb++;
        end
    endfunction

    function automatic void model_word(input logic [15:0] d, input int len, input bit fill,
                                       input bit low, input bit msb);
        int         nb;
        logic [63:0] v;
        logic [7:0] by;
        bit         b;
        nb = 8 * (len + 1);
        if (nb < DATA_W)       v = low ? (64'(d) >> (DATA_W - nb)) : (64'(d) % (64'd1 << nb));
        else if (nb == DATA_W) v = 64'(d);
        else                   v = fill ? (64'(d) << (nb - DATA_W)) : 64'(d);
        by = '0;
        for (int i = 0; i < nb; i++) begin
            b = msb ? v[nb-1-i] : v[i];
            sq.push_back(b);
            by = {by[6:0], b};
            if (i % 8 == 7) model_byte(by);
        end
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!pi_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!pi_ready) chk("ready_timeout", pi_ready, 1);
    endtask

    task automatic send_word(input logic [15:0] d, input int len, input bit fill,
                             input bit low, input bit msb);
        wait_ready();
        model_word(d, len, fill, low, msb);
        pi_data   = d;
        pi_length = LEN_W'(len);
        pi_fill   = fill;
        pi_low    = low;
        pi_msb    = msb;
        load      = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        chk("fmt_gap", so_valid, 0);
        @(negedge clk);
        chk("latency", so_valid, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sq.delete();
        wq.delete();
        mb      = 0;
        exp_ovf = 1'b0;
        n_fin   = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {pi_ready, so_valid, so_data, oem_addr, oem_dataout, odd_wr, even_wr,
                           oem_finish, oem_overflow}, 0);
        reset_n = 1'b1;
        #1 chk("ready_before_clk", pi_ready, 0);
        @(negedge clk);
        chk("ready_after_clk", pi_ready, 1);
    endtask

    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (reset_n) begin
            if (so_valid) begin
                chk("bit_expected", sq.size() != 0, 1);
                if (sq.size() != 0) chk("so_data", so_data, sq.pop_front());
            end
            if (odd_wr != 0 || even_wr != 0) begin
                chk("one_strobe", $countones({odd_wr, even_wr}), 1);
                chk("write_expected", wq.size() != 0, 1);
                if (wq.size() != 0) begin
                    e = wq.pop_front();
                    chk("write", {odd_wr, even_wr, oem_addr, oem_dataout},
                        {e.odd, e.even, e.addr, e.dat});
                end
                last_wr_cyc = cyc;
            end else if (oem_dataout != 0) begin
                chk("dout_idle", oem_dataout, 0);
            end
            if (oem_finish) begin
                n_fin++;
                chk("finish_timing", cyc, last_wr_cyc + 1);
            end
        end
    end

    initial begin
        int t;
        int len;
        do_reset();

        send_word(16'hA5C3, 0, 1'b0, 1'b1, 1'b1);
        send_word(16'h00B1, 0, 1'b0, 1'b0, 1'b0);
        send_word(16'h1234, 3, 1'b1, 1'b0, 1'b1);
        send_word(16'h1234, 2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++)
            send_word(16'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));

        wait_ready();
        while (mb < TOTAL) model_byte(8'h00);
        pi_end = 1'b1;
        @(posedge clk);
        #1 pi_end = 1'b0;
        t = 0;
        while (!oem_finish && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("finish_seen", oem_finish, 1);
        @(negedge clk);
        chk("finish_pulse_width", oem_finish, 0);
        chk("pad_drained", wq.size(), 0);
        chk("finish_count", n_fin, 1);
        load = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("done_not_ready", pi_ready, 0);
        end
        load = 1'b0;
        chk("done_no_output", sq.size(), 0);

        do_reset();
        send_word(16'hBEEF, 3, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async_abort", {so_valid, odd_wr, even_wr, pi_ready}, 0);
        do_reset();

        send_word(16'hA5C3, 0, 1'b0, 1'b1, 1'b1);
        while (mb < TOTAL) begin
            len = $urandom_range(0, 3);
            if (mb + len + 1 > TOTAL) len = TOTAL - mb - 1;
            send_word(16'($urandom), len, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        wait_ready();
        chk("no_overflow_yet", oem_overflow, 0);
        send_word(16'h5A5A, 0, 1'b0, 1'b0, 1'b1);
        wait_ready();
        chk("overflow", oem_overflow, exp_ovf);

        t = 0;
        while ((sq.size() != 0 || wq.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bits_drained", sq.size(), 0);
        chk("writes_drained", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
